port_map_commit_issuer: RTL
===========================

// Module: port_map_commit_issuer
// PURPOSE
//  Port-Map side of the commit handshake. Tracks one map-table entry per physical source port.
//  Sends allocation requests (O_Req/O_SrcPort) to the Commit unit. Turns unit-completion pulses
//  into one-hot commit requests (O_Commit), holds each until the Commit unit returns the matching
//  I_Ack bit, then frees the entry. Sits between dispatch/units and the Commit unit.
// PARAMETERS
//  NUM_UNITS    8    number of physical source ports / map-table entries
//  WIDTH_PID    3    port-ID width, $clog2(NUM_UNITS)
//  ACK_TIMEOUT  64   cycles O_Commit may wait for I_Ack before O_Error is flagged
// PORTS
//  clock        in   1          system clock
//  reset        in   1          synchronous, active-high reset
//  I_Alloc      in   1          allocation request from dispatch
//  I_AllocPort  in   WIDTH_PID  port ID to allocate
//  O_AllocNack  out  1          allocation rejected (1-cycle pulse)
//  I_Done       in   NUM_UNITS  completion pulses from units, any number per cycle
//  I_CommitFull in   1          Commit unit buffer full
//  I_Ack        in   NUM_UNITS  ack from Commit unit; bit p clears entry p
//  O_Req        out  1          allocation request to Commit unit (1-cycle pulse)
//  O_SrcPort    out  WIDTH_PID  port ID accompanying O_Req
//  O_Commit     out  NUM_UNITS  one-hot commit request to Commit unit, held until acked
//  O_Valid      out  NUM_UNITS  entry p not FREE
//  O_Busy       out  1          |O_Valid
//  O_Error      out  1          sticky: spurious I_Done or ack timeout
// BEHAVIOUR
//  Reset:
//   - Synchronous, active-high; all entries go to FREE.
//   - All outputs are 0; the round-robin pointer is 0 and the timeout counter is 0.
//   - Reset asserted mid-operation abandons any held O_Commit. The output is 0 the cycle after reset.
//  Entry FSM, evaluated on the state at the start of each cycle:
//   - FREE -> MAPPED when an allocation is accepted.
//   - MAPPED -> DONE_PEND on I_Done[p].
//   - DONE_PEND -> COMMITTING when granted.
//   - COMMITTING -> FREE on I_Ack[p].
//  Allocation:
//   - Accepted iff I_Alloc, entry[I_AllocPort]==FREE and !I_CommitFull.
//   - On accept: O_Req=1 and O_SrcPort=I_AllocPort are registered, appearing the next cycle.
//   - Otherwise O_AllocNack=1 the next cycle and no state changes.
//  Completion:
//   - I_Done[p] on a FREE entry sets O_Error and is otherwise ignored. This includes a done on the
//     same cycle as p's allocation.
//   - I_Done[p] on DONE_PEND or COMMITTING is ignored and is not an error.
//  Commit issue, at most one in flight:
//   - Grant only when no entry is COMMITTING and O_Commit is 0 this cycle. This guarantees at least
//     one all-zero O_Commit cycle between commits.
//   - Pick the first DONE_PEND entry at or after the RR pointer, wrapping NUM_UNITS-1 -> 0.
//   - O_Commit = onehot(grant) is registered and appears the next cycle; the pointer becomes grant+1.
//   - O_Commit stays asserted while the entry is COMMITTING.
//   - I_Ack[p] with p COMMITTING: the entry goes to FREE and O_Commit is 0 the next cycle.
//   - I_Ack bits for other entries are ignored.
//  Timeout:
//   - The counter increments each cycle O_Commit != 0 and clears on ack.
//   - When the counter reaches ACK_TIMEOUT, O_Error is set; the block keeps waiting.
//   - The counter saturates.
//  Simultaneous events:
//   - An ack and a new grant never occur in the same cycle, because of the gap rule.
//   - An allocation to a port freed by an ack in the same cycle is NACKed, since the FSM uses the
//     start-of-cycle state.
//  O_Valid and O_Busy are registered and reflect the post-update state.
// TESTING
//  1. Reset, alloc port 3 -> O_Req=1, O_SrcPort=3 at +1. I_Done[3] -> O_Commit=8'h08 at +1 after
//     grant. I_Ack[3] -> O_Commit=0 at +1, O_Valid[3]=0.
//  2. Alloc port 3 twice (second before free) -> second gives O_AllocNack=1, no O_Req.
//     Alloc with I_CommitFull=1 -> NACK.
//  3. Ports 1, 5, 6 mapped; I_Done=8'h62 in one cycle -> commits 8'h02, 8'h20, 8'h40 in that
//     order, each held to its ack, with >=1 zero cycle between.
//  4. RR wrap: pointer=7, ports 0 and 7 DONE_PEND -> grant 7 then 0.
//  5. I_Done[2] with port 2 FREE -> O_Error=1 sticky. Withhold I_Ack for ACK_TIMEOUT cycles ->
//     O_Error=1, O_Commit still held. Late ack still frees the entry.
//  6. Assert reset while O_Commit=8'h10 -> O_Commit=0, O_Busy=0, O_Error=0 the next cycle.

Source files
------------

// File: rtl/port_map_commit_issuer_if.sv
// Handshake bundle between the port-map commit issuer and its neighbours
// (dispatch, units, Commit unit).
interface port_map_commit_issuer_if #(
    parameter int NUM_UNITS = 8,
    parameter int WIDTH_PID = 3
);
    logic                 I_Alloc;
    logic [WIDTH_PID-1:0] I_AllocPort;
    logic                 O_AllocNack;
    logic [NUM_UNITS-1:0] I_Done;
    logic                 I_CommitFull;
    logic [NUM_UNITS-1:0] I_Ack;
    logic                 O_Req;
    logic [WIDTH_PID-1:0] O_SrcPort;
    logic [NUM_UNITS-1:0] O_Commit;
    logic [NUM_UNITS-1:0] O_Valid;
    logic                 O_Busy;
    logic                 O_Error;

    modport slave (
        input  I_Alloc, I_AllocPort, I_Done, I_CommitFull, I_Ack,
        output O_AllocNack, O_Req, O_SrcPort, O_Commit, O_Valid, O_Busy, O_Error
    );

    modport master (
        output I_Alloc, I_AllocPort, I_Done, I_CommitFull, I_Ack,
        input  O_AllocNack, O_Req, O_SrcPort, O_Commit, O_Valid, O_Busy, O_Error
    );
endinterface

// File: rtl/port_map_commit_issuer.sv
// Per-port map-table entries feeding a single-in-flight, round-robin commit
// request stream to the Commit unit, with ack timeout and spurious-done flagging.
module port_map_commit_issuer #(
    parameter int NUM_UNITS   = 8,
    parameter int WIDTH_PID   = 3,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    port_map_commit_issuer_if.slave  bus
);
    typedef enum logic [1:0] {FREE, MAPPED, DONE_PEND, COMMITTING} entry_state_t;
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    entry_state_t         state     [NUM_UNITS];
    entry_state_t         state_nxt [NUM_UNITS];
    logic [WIDTH_PID-1:0] rr_ptr;
    logic [CNT_W-1:0]     wait_cnt;

    logic                 accept;
    logic                 any_committing;
    logic                 found;
    logic                 grant_vld;
    logic [WIDTH_PID-1:0] grant_idx;
    logic [NUM_UNITS-1:0] pend;
    logic [NUM_UNITS-1:0] spurious;
    logic [NUM_UNITS-1:0] ack_hit;
    logic [NUM_UNITS-1:0] valid_nxt;
    logic [NUM_UNITS-1:0] commit_onehot;
    logic                 commit_active;

    assign commit_active = |bus.O_Commit;

    // All decisions use the start-of-cycle entry states.
    always_comb begin
        any_committing = 1'b0;
        pend           = '0;
        spurious       = '0;
        ack_hit        = '0;
        for (int p = 0; p < NUM_UNITS; p++) begin
            pend[p]     = (state[p] == DONE_PEND);
            spurious[p] = bus.I_Done[p] && (state[p] == FREE);
            ack_hit[p]  = bus.I_Ack[p] && (state[p] == COMMITTING);
            if (state[p] == COMMITTING) any_committing = 1'b1;
        end
        accept = bus.I_Alloc && (state[bus.I_AllocPort] == FREE) && !bus.I_CommitFull;
    end

    // Round-robin search starting at rr_ptr.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
            if (!found && pend[idx]) begin
                found     = 1'b1;
                grant_idx = WIDTH_PID'(idx);
            end
        end
        // Requiring O_Commit low as well forces a zero cycle between commits.
        grant_vld = found && !any_committing && !commit_active;
        commit_onehot            = '0;
        commit_onehot[grant_idx] = 1'b1;
    end

    always_comb begin
        for (int p = 0; p < NUM_UNITS; p++) begin
            state_nxt[p] = state[p];
            case (state[p])
                FREE:       if (accept && bus.I_AllocPort == WIDTH_PID'(p)) state_nxt[p] = MAPPED;
                MAPPED:     if (bus.I_Done[p]) state_nxt[p] = DONE_PEND;
                DONE_PEND:  if (grant_vld && grant_idx == WIDTH_PID'(p)) state_nxt[p] = COMMITTING;
                COMMITTING: if (bus.I_Ack[p]) state_nxt[p] = FREE;
                default:    state_nxt[p] = FREE;
            endcase
            valid_nxt[p] = (state_nxt[p] != FREE);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int p = 0; p < NUM_UNITS; p++) state[p] <= FREE;
            rr_ptr          <= '0;
            wait_cnt        <= '0;
            bus.O_AllocNack <= 1'b0;
            bus.O_Req       <= 1'b0;
            bus.O_SrcPort   <= '0;
            bus.O_Commit    <= '0;
            bus.O_Valid     <= '0;
            bus.O_Busy      <= 1'b0;
            bus.O_Error     <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_UNITS; p++) state[p] <= state_nxt[p];
            bus.O_Valid     <= valid_nxt;
            bus.O_Busy      <= |valid_nxt;
            bus.O_Req       <= accept;
            bus.O_SrcPort   <= accept ? bus.I_AllocPort : '0;
            bus.O_AllocNack <= bus.I_Alloc && !accept;

            if (grant_vld) begin
                bus.O_Commit <= commit_onehot;
                rr_ptr       <= (grant_idx == WIDTH_PID'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
            end else if (|ack_hit) begin
                bus.O_Commit <= '0;
            end

            // Timeout keeps waiting after flagging; the counter saturates.
            if (|ack_hit)
                wait_cnt <= '0;
            else if (commit_active && wait_cnt < CNT_W'(ACK_TIMEOUT))
                wait_cnt <= wait_cnt + 1'b1;

            if (|spurious ||
                (commit_active && !(|ack_hit) && wait_cnt == CNT_W'(ACK_TIMEOUT - 1)))
                bus.O_Error <= 1'b1;
        end
    end
endmodule
